io_port_arbiter: RTL
====================

Name: io_port_arbiter

Overview:
Sequences and shares the memory-mapped IO port block between two requesters: requester A (CPU core) and requester B (DMA/poll engine). Each request is one byte-wide read or write to port address `0..NUM_PORTS-1`. The block arbitrates round-robin and drives the IO port's `addr`/`RE`/`WE`/`Din` with a fixed setup/strobe/release timing. It captures `Dout` on reads and returns data to the requester with a one-cycle `ack`. It sits between the core/DMA bus and the IO port block.

Parameters:
- NUM_PORTS, 8, number of valid IO port addresses; addresses `>= NUM_PORTS` are errors.
- STROBE_CYCLES, 2, cycles `RE`/`WE` is held high per access (legal range 1..15).
- ADDR_W, 8, address width.
- DATA_W, 8, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A transaction request; held until `a_ack`.
- a_we  in  1  A: 1 = write, 0 = read; stable while `a_req`.
- a_addr  in  ADDR_W  A port address.
- a_wdata  in  DATA_W  A write data.
- a_ack  out  1  A one-cycle completion pulse.
- a_err  out  1  A error flag, valid with `a_ack`.
- a_rdata  out  DATA_W  A read data, valid with `a_ack`; held until next A ack.
- b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata  same as A, for requester B.
- addr  out  ADDR_W  to IO port address.
- RE  out  1  to IO port read strobe.
- WE  out  1  to IO port write strobe.
- Din  out  DATA_W  to IO port write data.
- Dout  in  DATA_W  from IO port read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): state = IDLE; `addr=0`, `Din=0`, `RE=0`, `WE=0`; both acks, errs and rdatas = 0; `busy=0`; last-grant pointer = B, so A wins the first tie. All outputs are registered.
- Reset mid-access drops `RE`/`WE` immediately. The interrupted transaction is lost with no ack, and the requester must re-request.
- IDLE: samples `a_req`/`b_req` each edge.
  - One requester high: grant it.
  - Both high: grant the one not granted last, then update the pointer.
  - Latch the winner's `we`, `addr` and `wdata` into internal registers; inputs are not re-sampled after grant.
  - Go to SETUP, or to DONE if `addr >= NUM_PORTS`.
- SETUP (1 cycle): `addr`/`Din` (`Din` for writes only; otherwise unchanged) driven from latched values; `RE=WE=0`. Next state is STROBE with counter = `STROBE_CYCLES-1`.
- STROBE (`STROBE_CYCLES` cycles): `RE=1` for read or `WE=1` for write; `addr`/`Din` stable. The counter decrements each cycle. At counter 0:
  - a read captures `Dout` into the granted rdata register on that edge;
  - next state is DONE with `RE`/`WE` deasserted at that same edge.
- DONE (1 cycle): granted ack = 1; err = 1 only for an out-of-range address (rdata forced 0, no strobe ever issued). `addr` is held. Next state is IDLE.
- Latency from request sampled in IDLE to ack:
  - valid access: `2 + STROBE_CYCLES` cycles (4 at default);
  - error: 1 cycle.
- The requester must drop `req` in the cycle after seeing ack. A `req` still high in IDLE is a new transaction.
- The losing requester waits; its `req` stays high and it wins at the next IDLE (round-robin). Worst-case wait is one transaction.
- `RE` and `WE` are never high simultaneously. Neither strobe is ever high in IDLE, SETUP or DONE.
- `addr`, `we` or `wdata` changing while `req` is high is ignored after grant.
- Address width: the compare is unsigned; `addr = NUM_PORTS-1` is valid, `addr = NUM_PORTS` is an error.

Decomposition:
- Package `io_arb_pkg`:
  - state encoding constants `S_IDLE`, `S_SETUP`, `S_STROBE`, `S_DONE` (2-bit);
  - `GNT_A`/`GNT_B` constants;
  - default `NUM_PORTS` and `STROBE_CYCLES`.
- Sub-module `rr_arbiter2`: a 2-way round-robin arbiter.
  - Inputs: `req[1:0]`, `update`.
  - Output: one-hot `gnt[1:0]`.
  - Internal last-grant register, asynchronously reset to B.
- The FSM, strobe counter and datapath registers stay in the top module.

Test Plan:
- A writes `8'hA5` to addr 3:
  - `a_req` rises in IDLE → SETUP (`addr=3`, `Din=A5`, strobes 0);
  - then 2 cycles `WE=1`;
  - then `a_ack=1`, `a_err=0` exactly 4 cycles after grant; `RE` stays 0 throughout.
- B reads addr 5 with `Dout` driving `8'h19`:
  - `RE=1` for 2 cycles, `WE=0`;
  - `b_ack` pulses with `b_rdata=8'h19`; `a_ack` stays 0.
- A and B request simultaneously from reset:
  - A granted first (`a_ack` at cycle 4), B granted at the next IDLE (`b_ack` 5 cycles later);
  - a repeat of the simultaneous request then grants B first.
- A requests addr 8 (`NUM_PORTS=8`):
  - `a_ack=1`, `a_err=1`, `a_rdata=0` one cycle after grant;
  - `RE`/`WE` never rise; addr 7 completes normally with `err=0`.
- Assert `rst` during the first STROBE cycle of a write to addr 2:
  - `WE` drops without waiting for a clock edge;
  - all outputs return to 0, state IDLE, no ack;
  - after release, the re-issued request completes in 4 cycles.
- `STROBE_CYCLES=1` variant: a read of addr 0 gives `RE` high for exactly 1 cycle and ack 3 cycles after grant.

Source files
------------

// File: rtl/io_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_arb_pkg
// Purpose  : Shared state encoding, grant codes and defaults for the IO arbiter
// Revision : 1.0  initial release
// ============================================================================
package io_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [1:0] GNT_A = 2'b01;
    localparam logic [1:0] GNT_B = 2'b10;

    localparam int unsigned DEF_NUM_PORTS     = 8;
    localparam int unsigned DEF_STROBE_CYCLES = 2;

endpackage
`default_nettype wire

// File: rtl/io_port_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin arbiter; the pointer moves only on a tie
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import io_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    logic last_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q <= 1'b1;
        end else if (update_i) begin
            last_b_q <= gnt_o[1];
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_b_q ? GNT_A : GNT_B;
        end else if (req_i[0]) begin
            gnt_o = GNT_A;
        end else if (req_i[1]) begin
            gnt_o = GNT_B;
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : io_port_arbiter
// Purpose  : Shares the IO port block between two requesters with fixed
//            setup / strobe / release timing and registered outputs
// Revision : 1.0  initial release
// ============================================================================
module io_port_arbiter
    import io_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = DEF_NUM_PORTS,
    parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DATA_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic              RE,
    output logic              WE,
    output logic [DATA_W-1:0] Din,
    input  logic [DATA_W-1:0] Dout,
    output logic              busy
);

    localparam logic [ADDR_W:0] C_NUM_PORTS   = (ADDR_W+1)'(NUM_PORTS);
    localparam logic [3:0]      C_STROBE_LAST = 4'(STROBE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                gnt_b_q, gnt_b_d;
    logic                op_wr_q, op_wr_d;
    logic                op_err_q, op_err_d;
    logic                re_q, re_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic                a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                busy_q, busy_d;

    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    logic                w_update;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_bad;

    assign w_req    = {b_req, a_req};
    assign w_update = (state_q == S_IDLE) && (w_req == 2'b11);

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (w_req),
        .update_i (w_update),
        .gnt_o    (w_gnt)
    );

    assign w_sel_we    = w_gnt[1] ? b_we    : a_we;
    assign w_sel_addr  = w_gnt[1] ? b_addr  : a_addr;
    assign w_sel_wdata = w_gnt[1] ? b_wdata : a_wdata;
    assign w_sel_bad   = ({1'b0, w_sel_addr} >= C_NUM_PORTS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            gnt_b_q   <= 1'b0;
            op_wr_q   <= 1'b0;
            op_err_q  <= 1'b0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_b_q   <= gnt_b_d;
            op_wr_q   <= op_wr_d;
            op_err_q  <= op_err_d;
            re_q      <= re_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_b_d   = gnt_b_q;
        op_wr_d   = op_wr_q;
        op_err_d  = op_err_q;
        re_d      = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_err_d   = 1'b0;
        b_err_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (|w_req) begin
                    gnt_b_d  = w_gnt[1];
                    op_wr_d  = w_sel_we;
                    op_err_d = w_sel_bad;
                    // Out-of-range requests never touch the port pins.
                    if (w_sel_bad) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETUP;
                        addr_d  = w_sel_addr;
                        if (w_sel_we) begin
                            din_d = w_sel_wdata;
                        end
                    end
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = C_STROBE_LAST;
                re_d    = ~op_wr_q;
                we_d    = op_wr_q;
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    if (!op_wr_q) begin
                        if (gnt_b_q) b_rdata_d = Dout;
                        else         a_rdata_d = Dout;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    re_d  = re_q;
                    we_d  = we_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                a_ack_d = ~gnt_b_q;
                b_ack_d = gnt_b_q;
                a_err_d = ~gnt_b_q & op_err_q;
                b_err_d = gnt_b_q & op_err_q;
                if (op_err_q) begin
                    if (gnt_b_q) b_rdata_d = '0;
                    else         a_rdata_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign addr    = addr_q;
    assign Din     = din_q;
    assign RE      = re_q;
    assign WE      = we_q;
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_err   = a_err_q;
    assign b_err   = b_err_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire
